// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the shared-counter round-robin scheduler.
// The round-robin search is sized for up to MaxReq requesters.
package counter_sched_pkg;

   localparam int unsigned DefaultCw = 6;
   localparam int unsigned MaxReq    = 8;
   localparam int unsigned IdxW      = 3;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StRun,
      StDone
   } state_e;

   typedef struct packed {
      logic            valid;
      logic [IdxW-1:0] idx;
   } rr_pick_t;

   // Lowest requester index at or above ptr, wrapping at n_req; ptr must be below n_req.
   function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] req,
                                        input logic [IdxW-1:0]   ptr,
                                        input int unsigned       n_req);
      rr_pick_t    r;
      int unsigned idx;
      r.valid = 1'b0;
      r.idx   = '0;
      idx     = 0;
      for (int unsigned off = 0; off < MaxReq; off++) begin
         if (off < n_req && !r.valid) begin
            idx = 32'(ptr) + off;
            if (idx >= n_req) begin
               idx = idx - n_req;
            end
            if (req[idx[IdxW-1:0]]) begin
               r.valid = 1'b1;
               r.idx   = idx[IdxW-1:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin picker: one-hot winner plus its index, searching upward from ptr.
// Usable on its own by clients that only need arbitration.
module rr_arbiter
   import counter_sched_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   localparam int unsigned PW   = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PW-1:0]    ptr_i,
   output logic [N_REQ-1:0] pick_o,
   output logic [PW-1:0]    idx_o,
   output logic             any_o
);

   rr_pick_t r;

   always_comb begin
      r      = rr_pick(MaxReq'(req_i), IdxW'(ptr_i), N_REQ);
      any_o  = r.valid;
      idx_o  = PW'(r.idx);
      pick_o = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         pick_o[i] = r.valid && (r.idx == IdxW'(i));
      end
   end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one up-counter among N_REQ requesters; each grant counts
// a latched duration and ends with a one-cycle done pulse to the granted requester.
module counter_sched
   import counter_sched_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned CW    = DefaultCw,
   localparam int unsigned PW   = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*CW-1:0] dur,
   output logic [N_REQ-1:0]    gnt,
   output logic [N_REQ-1:0]    done,
   output logic                busy,
   output logic [CW-1:0]       count
);

   state_e           state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    w_q, w_d;
   logic [CW-1:0]    dlat_q, dlat_d;
   logic [CW-1:0]    count_q, count_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic             busy_q, busy_d;

   logic [N_REQ-1:0] pick;
   logic [PW-1:0]    pick_idx;
   logic             pick_any;
   logic [CW-1:0]    dur_sel;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .req_i  (req),
      .ptr_i  (ptr_q),
      .pick_o (pick),
      .idx_o  (pick_idx),
      .any_o  (pick_any)
   );

   always_comb begin
      dur_sel = dur[pick_idx*CW +: CW];
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      w_d     = w_q;
      dlat_d  = dlat_q;
      count_d = count_q;
      gnt_d   = gnt_q;
      unique case (state_q)
         StIdle: begin
            if (pick_any) begin
               w_d     = pick_idx;
               dlat_d  = dur_sel;
               gnt_d   = pick;
               state_d = StLoad;
            end
         end
         StLoad: begin
            count_d = '0;
            state_d = (dlat_q == '0) ? StDone : StRun;
         end
         StRun: begin
            // Stop one short of dlat so the count never wraps and RUN lasts dlat cycles.
            if (count_q == dlat_q - CW'(1)) begin
               state_d = StDone;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         StDone: begin
            gnt_d   = '0;
            count_d = '0;
            ptr_d   = (w_q == PW'(N_REQ - 1)) ? '0 : w_q + PW'(1);
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      done_d = (state_d == StDone) ? gnt_d : '0;
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         w_q     <= '0;
         dlat_q  <= '0;
         count_q <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         w_q     <= w_d;
         dlat_q  <= dlat_d;
         count_q <= count_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt   = gnt_q;
   assign done  = done_q;
   assign busy  = busy_q;
   assign count = count_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed and randomized bench for counter_sched, checked against a timeline model that
// predicts outputs from cycles elapsed since each grant.
module tb_counter_sched;

   localparam int N  = 4;
   localparam int CW = 6;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*CW-1:0] dur;
   logic [N-1:0]    gnt;
   logic [N-1:0]    done;
   logic            busy;
   logic [CW-1:0]   count;

   logic [CW-1:0]   dur_a [N];

   int checks   = 0;
   int failures = 0;

   // Model: grant owner, its duration, and cycles elapsed since the grant edge.
   bit m_active;
   int m_ptr;
   int m_w;
   int m_d;
   int m_t;

   counter_sched #(
      .N_REQ (N),
      .CW    (CW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .dur   (dur),
      .gnt   (gnt),
      .done  (done),
      .busy  (busy),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      dur = '0;
      for (int i = 0; i < N; i++) begin
         dur[i*CW +: CW] = dur_a[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_count();
      if (!m_active || m_t <= 1) return 0;
      if (m_t <= m_d + 1) return m_t - 2;
      return (m_d == 0) ? 0 : m_d - 1;
   endfunction

   task automatic check_outputs();
      int oh;
      oh = m_active ? (1 << m_w) : 0;
      chk("gnt", 32'(gnt), oh);
      chk("busy", 32'(busy), m_active ? 1 : 0);
      chk("done", 32'(done), (m_active && m_t == m_d + 2) ? oh : 0);
      chk("count", 32'(count), exp_count());
   endtask

   task automatic model_edge();
      if (m_active) begin
         m_t++;
         if (m_t == m_d + 3) begin
            m_active = 1'b0;
            m_ptr    = (m_w + 1) % N;
         end
      end else if (req != '0) begin
         for (int off = N - 1; off >= 0; off--) begin
            if (req[(m_ptr + off) % N]) m_w = (m_ptr + off) % N;
         end
         m_d      = int'(dur_a[m_w]);
         m_t      = 1;
         m_active = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      check_outputs();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Called 1 time unit after a rising edge: asserts reset mid-cycle, releases at the falling edge.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      m_active = 1'b0;
      m_ptr    = 0;
      check_outputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int guard;
      rst      = 1'b0;
      req      = '0;
      m_active = 1'b0;
      m_ptr    = 0;
      m_w      = 0;
      m_d      = 0;
      m_t      = 0;
      for (int i = 0; i < N; i++) dur_a[i] = '0;
      #3;
      do_reset();

      // Single request, duration 5.
      req      = 4'b0001;
      dur_a[0] = 6'd5;
      tick();
      req = '0;
      ticks(9);

      // Fairness starts from ptr 0.
      tick();
      do_reset();
      for (int i = 0; i < N; i++) dur_a[i] = 6'd2;
      req = 4'b1111;
      ticks(26);
      req = '0;
      ticks(6);

      // Zero duration.
      req      = 4'b0100;
      dur_a[2] = 6'd0;
      tick();
      req = '0;
      ticks(4);

      // Request withdrawn after the first RUN cycle.
      req      = 4'b0010;
      dur_a[1] = 6'd4;
      ticks(3);
      req = '0;
      ticks(6);

      // Maximum duration.
      req      = 4'b0010;
      dur_a[1] = 6'd63;
      tick();
      req = '0;
      ticks(68);

      // Reset while count is 3, then ptr must be back at 0.
      req      = 4'b0010;
      dur_a[1] = 6'd10;
      tick();
      req   = '0;
      guard = 0;
      while (!(m_active && exp_count() == 3) && guard < 20) begin
         tick();
         guard++;
      end
      chk("reach_count3", 32'(count), 3);
      do_reset();
      req      = 4'b1001;
      dur_a[0] = 6'd1;
      dur_a[3] = 6'd1;
      tick();
      chk("post_reset_winner", 32'(gnt), 1);
      req = '0;
      ticks(5);

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) dur_a[$urandom_range(0, N - 1)] = 6'($urandom_range(0, 9));
         if (c == 250) begin
            do_reset();
         end else begin
            tick();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
